// File: rtl/tdc_ctrl_pkg.sv
// rtl/tdc_ctrl_pkg.sv - shared types and defaults for the TDC coarse measurement controller
package tdc_ctrl_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } tdc_state_t;

    // Result record at the default counter width.
    typedef struct packed {
        logic                 timeout;
        logic [DEF_CNT_W-1:0] count;
    } tdc_result_t;

endpackage

// File: rtl/tdc_measure_ctrl_edge.sv
// rtl/tdc_measure_ctrl_edge.sv - synchronizer plus rising-edge pulse generator for one async input
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   async_in   asynchronous level input
//   pulse      registered one-cycle pulse on each synchronized rising edge
module async_edge_pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   history;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            history <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            history <= sync_q[SYNC_STAGES-1];
            // Rise seen at the end of the chain but not yet in history.
            pulse   <= sync_q[SYNC_STAGES-1] & ~history;
        end
    end

endmodule

// File: rtl/tdc_measure_ctrl.sv
// rtl/tdc_measure_ctrl.sv - arm/start/stop sequencing and coarse cycle count for one TDC measurement
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   arm, abort      clk-domain controls: arm a measurement / cancel armed or running one
//   start_async     asynchronous start event (rising edge)
//   stop_async      asynchronous stop event (rising edge)
//   busy            high while ARMED or RUN
//   result_valid    result presented, held until result_ready
//   result_ready    consumer accepts result
//   result_count    coarse interval in clk cycles
//   result_timeout  measurement ended by timeout rather than stop
module tdc_measure_ctrl
    import tdc_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             start_async,
    input  logic             stop_async,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] result_count,
    output logic             result_timeout
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT_CYC < 1 || longint'(TIMEOUT_CYC) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    logic             start_pulse;
    logic             stop_pulse;
    tdc_state_t       state;
    logic [CNT_W-1:0] counter;

    async_edge_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_start_edge (
        .clk      (clk),
        .rst      (rst),
        .async_in (start_async),
        .pulse    (start_pulse)
    );

    async_edge_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_stop_edge (
        .clk      (clk),
        .rst      (rst),
        .async_in (stop_async),
        .pulse    (stop_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            counter        <= '0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_count   <= '0;
            result_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    // A stop coincident with start is simply not looked at here.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (start_pulse) begin
                        state   <= RUN;
                        counter <= CNT_W'(1);
                    end
                end
                RUN: begin
                    // Priority: abort, then stop, then timeout.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (stop_pulse) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        result_valid   <= 1'b1;
                        result_count   <= counter;
                        result_timeout <= 1'b0;
                    end else if (counter == TIMEOUT_VAL) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        result_valid   <= 1'b1;
                        result_count   <= TIMEOUT_VAL;
                        result_timeout <= 1'b1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// tb/tb_tdc_measure_ctrl.sv - scoreboard bench for tdc_measure_ctrl with a timing-level reference model
module tb_tdc_measure_ctrl;
    import tdc_ctrl_pkg::*;

    localparam int S       = 2;
    localparam int TIMEOUT = 1000;
    localparam int S3      = 3;
    localparam int TO3     = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0, abort = 1'b0, start_async = 1'b0, stop_async = 1'b0;
    logic        result_ready = 1'b0;
    logic        busy, result_valid, result_timeout;
    logic [15:0] result_count;

    logic        arm3 = 1'b0, abort3 = 1'b0, start3 = 1'b0, stop3 = 1'b0, ready3 = 1'b0;
    logic        busy3, valid3, timeout3;
    logic [15:0] count3;

    int compared   = 0;
    int mismatched = 0;
    int start_pulses = 0;
    bit count_en   = 1'b0;

    tdc_result_t exp_q[$];
    bit          seen = 1'b0;
    tdc_result_t held;

    always #5 clk = ~clk;

    tdc_measure_ctrl #(.SYNC_STAGES(S), .CNT_W(16), .TIMEOUT_CYC(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .start_async(start_async), .stop_async(stop_async),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .result_count(result_count), .result_timeout(result_timeout)
    );

    tdc_measure_ctrl #(.SYNC_STAGES(S3), .CNT_W(16), .TIMEOUT_CYC(TO3)) u_dut3 (
        .clk(clk), .rst(rst), .arm(arm3), .abort(abort3),
        .start_async(start3), .stop_async(stop3),
        .busy(busy3), .result_valid(valid3), .result_ready(ready3),
        .result_count(count3), .result_timeout(timeout3)
    );

    task automatic check(string name, longint act, longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the interval is the distance between the sampling edges of the
    // two rises; anything longer than TIMEOUT ends as a timeout at TIMEOUT.
    function automatic tdc_result_t model(int d);
        tdc_result_t r;
        r.timeout = (d > TIMEOUT);
        r.count   = (d > TIMEOUT) ? 16'(TIMEOUT) : 16'(d);
        return r;
    endfunction

    // Monitor: first valid cycle of each result is compared against the queue,
    // later valid cycles must repeat the same values.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (result_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                    held = {result_timeout, result_count};
                end else begin
                    held = exp_q.pop_front();
                    check("result_count", result_count, held.count);
                    check("result_timeout", result_timeout, held.timeout);
                end
                seen = 1'b1;
            end else begin
                check("stable_count", result_count, held.count);
                check("stable_timeout", result_timeout, held.timeout);
            end
            if (result_ready) seen = 1'b0;
        end
    end

    always @(posedge clk) if (count_en && u_dut.u_start_edge.pulse) start_pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(int bp);
        int n = 0;
        while (!result_valid && n < 2000) begin
            tick();
            n++;
        end
        if (!result_valid) check("wait_result_valid", 0, 1);
        check("busy_done", busy, 0);
        stop_async = 1'b1;
        for (int i = 0; i < bp; i++) begin
            arm = 1'($urandom_range(0, 1));
            tick();
        end
        arm = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("valid_after_handshake", result_valid, 0);
        check("busy_after_handshake", busy, 0);
    endtask

    task automatic measure(int d, int bp);
        exp_q.push_back(model(d));
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("busy_armed", busy, 1);
        ticks($urandom_range(0, 3));
        start_async = 1'b1;
        if (d <= TIMEOUT) begin
            ticks(d);
            stop_async = 1'b1;
        end
        drain(bp);
        start_async = 1'b0;
        stop_async  = 1'b0;
        ticks(S + 3);
    endtask

    initial begin
        int n;
        ticks(3);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_count", result_count, 0);
        check("rst_timeout", result_timeout, 0);
        rst = 1'b0;
        ticks(2);

        // Stop in IDLE is ignored.
        stop_async = 1'b1;
        ticks(6);
        check("idle_stop_busy", busy, 0);
        stop_async = 1'b0;
        ticks(5);

        measure(37, 0);
        measure(23, 20);
        measure(1001, 20);
        measure(1000, 1);

        // Simultaneous start/stop rise, later stop 5 cycles after start.
        exp_q.push_back(model(5));
        arm = 1'b1; tick(); arm = 1'b0;
        start_async = 1'b1; stop_async = 1'b1;
        ticks(2); stop_async = 1'b0;
        ticks(3); stop_async = 1'b1;
        drain(2);
        start_async = 1'b0; stop_async = 1'b0;
        ticks(S + 3);

        // Stop before start is ignored; back-to-back arm after handshake.
        exp_q.push_back(model(10));
        arm = 1'b1; tick(); arm = 1'b0;
        stop_async = 1'b1; ticks(4);
        stop_async = 1'b0; ticks(4);
        check("pre_stop_busy", busy, 1);
        start_async = 1'b1;
        ticks(10);
        stop_async = 1'b1;
        drain(3);
        arm = 1'b1; tick(); arm = 1'b0;
        check("b2b_arm_busy", busy, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        start_async = 1'b0; stop_async = 1'b0;
        ticks(S + 3);

        // Abort in ARMED.
        arm = 1'b1; tick(); arm = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_armed_busy", busy, 0);
        start_async = 1'b1; ticks(10);
        check("abort_armed_valid", result_valid, 0);
        start_async = 1'b0; ticks(S + 3);

        // Abort in RUN while the counter reads 12.
        arm = 1'b1; tick(); arm = 1'b0;
        start_async = 1'b1;
        ticks(S + 13);
        check("run_busy", busy, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_run_busy", busy, 0);
        ticks(5);
        check("abort_run_valid", result_valid, 0);
        start_async = 1'b0; ticks(S + 3);

        // Start held high for 50 cycles produces one pulse.
        start_pulses = 0; count_en = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        start_async = 1'b1; ticks(50);
        count_en = 1'b0;
        check("held_start_pulses", start_pulses, 1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Reset mid-RUN clears outputs immediately.
        arm = 1'b1; tick(); arm = 1'b0;
        start_async = 1'b0; ticks(S + 3);
        start_async = 1'b1; ticks(20);
        rst = 1'b1; #1;
        check("rst_run_busy", busy, 0);
        check("rst_run_valid", result_valid, 0);
        ticks(2);
        rst = 1'b0;
        ticks(8);
        check("rst_release_busy", busy, 0);
        start_async = 1'b0; ticks(S + 3);

        // Pulse latency in edges from the first sampling edge.
        start_async = 1'b1; n = 0;
        do begin tick(); n++; end while (!u_dut.u_start_edge.pulse && n < 10);
        check("latency_sync2", n, S + 1);
        start_async = 1'b0;
        start3 = 1'b1; n = 0;
        do begin tick(); n++; end while (!u_dut3.u_start_edge.pulse && n < 10);
        check("latency_sync3", n, S3 + 1);
        start3 = 1'b0; ticks(S3 + 3);

        // Second instance: short timeout.
        arm3 = 1'b1; tick(); arm3 = 1'b0;
        start3 = 1'b1; n = 0;
        while (!valid3 && n < 100) begin tick(); n++; end
        check("dut3_valid", valid3, 1);
        check("dut3_count", count3, TO3);
        check("dut3_timeout", timeout3, 1);
        ready3 = 1'b1; tick(); ready3 = 1'b0;
        check("dut3_drained", valid3, 0);
        start3 = 1'b0; ticks(S3 + 3);

        for (int i = 0; i < 8; i++) measure(int'($urandom_range(1, 80)), int'($urandom_range(0, 6)));

        ticks(5);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
